alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of the ALU control code (minimum 4).
REQ-002 SHALL have parameter MUL_CYCLES, default 3, number of cycles from acceptance to result for MUL (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 16, width of the saturating accepted-operation counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 flush  input  1  synchronous abort of the in-flight operation.
REQ-007 in_valid  input  1  decode fields valid.
REQ-008 in_ready  output  1  block can accept this cycle.
REQ-009 alu_op  input  2  operation class: 00 store, 01 branch, 10 R-type, 11 I-type.
REQ-010 func3  input  3  instruction funct3.
REQ-011 func7_5  input  1  funct7 bit 5, SUB/SRA select.
REQ-012 func7_0  input  1  funct7 bit 0, M-extension select.
REQ-013 out_valid  output  1  alu_ctrl/illegal valid.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 alu_ctrl  output  CTRL_W  registered ALU control code.
REQ-016 illegal  output  1  registered: the accepted encoding was unsupported.
REQ-017 busy  output  1  multi-cycle operation in progress.
REQ-018 op_count  output  CNT_W  number of accepted operations, saturating.

Function
REQ-019 Codes SHALL be zero-extended to CTRL_W: ADD 0, SUB 1, AND 2, OR 3, SLTU 4, SLT 5, XOR 6, SLL 7, SRL 8, SRA 9, MUL 10.
REQ-020 Decode by class:
- alu_op 00: ADD.
- alu_op 01: SUB.
- alu_op 10 with func7_0=1: MUL if func3=000, otherwise illegal.
- alu_op 10 with func7_0=0, by func3: 000 ADD/SUB (func7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (func7_5), 110 OR, 111 AND.
REQ-021 Decode for alu_op 11 SHALL use the same func3 map as REQ-020 with func7_0 ignored, except func3=000 is always ADD.
REQ-022 An illegal encoding SHALL produce alu_ctrl=0 and illegal=1; the output SHALL never be high-impedance or X.
REQ-023 The FSM SHALL have three states:
- IDLE: no result held.
- WAIT: MUL counting.
- HOLD: result presented.
REQ-024 in_ready SHALL be 1 in IDLE, and 1 in HOLD when out_ready=1; it SHALL be 0 in WAIT and whenever flush=1.
REQ-025 A transfer SHALL occur when in_valid and in_ready are both 1; decode fields SHALL be sampled only on a transfer.
REQ-026 Non-MUL transfer: the result SHALL be registered and the FSM SHALL go to HOLD, so out_valid rises the next cycle (latency 1).
REQ-027 MUL transfer with MUL_CYCLES=1: SHALL behave as REQ-026.
REQ-028 MUL transfer with MUL_CYCLES>1: SHALL go to WAIT with the counter loaded to MUL_CYCLES-1, decrement each cycle, and enter HOLD when it reaches 1, so out_valid rises MUL_CYCLES cycles after the transfer.
REQ-029 busy SHALL equal (state==WAIT).
REQ-030 HOLD with out_ready=1 and no new transfer SHALL go to IDLE.
REQ-031 HOLD with out_ready=1 and a simultaneous transfer SHALL load the new result with no bubble.
REQ-032 HOLD with out_ready=0 SHALL keep alu_ctrl and illegal stable.
REQ-033 flush=1 SHALL force IDLE, clear out_valid and the counter, and block acceptance that cycle; op_count is unaffected.
REQ-034 op_count SHALL increment on each transfer, including illegal ones, and SHALL hold at 2^CNT_W-1.

Reset
REQ-035 On rst=0, immediately and independent of clk: state IDLE, out_valid=0, alu_ctrl=0, illegal=0, busy=0, op_count=0, counter=0.
REQ-036 Reset asserted mid-WAIT or mid-HOLD SHALL discard the operation; after release the first transfer SHALL behave as from IDLE.

Verification
REQ-037 alu_op=10, func3=101, func7_5=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=9, illegal=0.
REQ-038 alu_op=10, func7_0=1, func3=000, default MUL_CYCLES=3 -> busy for 2 cycles, out_valid=1 with alu_ctrl=10 exactly 3 cycles after the transfer; in_ready=0 meanwhile.
REQ-039 alu_op=10, func7_0=1, func3=100 -> alu_ctrl=0, illegal=1, op_count increments.
REQ-040 Ops ADD then OR back-to-back with out_ready=1 -> out_valid stays high on consecutive cycles with alu_ctrl 0 then 3; with out_ready=0 -> in_ready=0 and alu_ctrl=0 held.
REQ-041 flush in WAIT -> next cycle IDLE, busy=0, out_valid=0; rst pulse in HOLD -> all outputs 0 asynchronously.
REQ-042 CNT_W=2, 5 transfers -> op_count=3.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Decode/result handshake bundle for alu_op_sequencer.
// The master side drives decode fields and consumes results; the slave side is the sequencer.
interface alu_op_sequencer_if #(
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [2:0]        func3;
    logic              func7_5;
    logic              func7_0;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output flush, in_valid, alu_op, func3, func7_5, func7_0, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, busy, op_count
    );

    modport slave (
        input  flush, in_valid, alu_op, func3, func7_5, func7_0, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, busy, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes RISC-V class/funct fields into an ALU control code and sequences the result
// through a valid/ready handshake, holding MUL for MUL_CYCLES cycles before presenting it.
module alu_op_sequencer #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
        logic              is_mul;
    } dec_t;

    localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_CYCLES - 1);

    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] C_MUL  = CTRL_W'(10);

    state_t            r_state;
    logic [MC_W-1:0]   r_mul_cnt;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_op_count;

    dec_t w_dec;
    logic w_in_ready;
    logic w_xfer;

    // Shared funct3 map; I-type has no SUB, so func7_5 only matters for shifts there.
    function automatic logic [CTRL_W-1:0] f3_ctrl(input logic [2:0] f3, input logic f7_5,
                                                  input logic i_type);
        logic [CTRL_W-1:0] c;
        c = C_ADD;
        case (f3)
            3'b000: c = (f7_5 && !i_type) ? C_SUB : C_ADD;
            3'b001: c = C_SLL;
            3'b010: c = C_SLT;
            3'b011: c = C_SLTU;
            3'b100: c = C_XOR;
            3'b101: c = f7_5 ? C_SRA : C_SRL;
            3'b110: c = C_OR;
            3'b111: c = C_AND;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: default every field first so no path through the case can infer a latch.
        w_dec = '0;
        unique case (bus.alu_op)
            2'b00: w_dec.ctrl = C_ADD;
            2'b01: w_dec.ctrl = C_SUB;
            2'b10: begin
                if (bus.func7_0) begin
                    if (bus.func3 == 3'b000) begin
                        w_dec.ctrl   = C_MUL;
                        w_dec.is_mul = 1'b1;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end else begin
                    w_dec.ctrl = f3_ctrl(bus.func3, bus.func7_5, 1'b0);
                end
            end
            default: w_dec.ctrl = f3_ctrl(bus.func3, bus.func7_5, 1'b1);
        endcase
    end

    assign w_in_ready = !bus.flush &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready));
    assign w_xfer     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mul_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
            r_illegal   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            if (bus.flush) begin
                r_state     <= S_IDLE;
                r_mul_cnt   <= '0;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_WAIT: begin
                        if (r_mul_cnt == MC_W'(1)) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_mul_cnt   <= '0;
                        end else begin
                            r_mul_cnt <= r_mul_cnt - MC_W'(1);
                        end
                    end
                    default: begin
                        if (w_xfer) begin
                            r_alu_ctrl <= w_dec.ctrl;
                            r_illegal  <= w_dec.illegal;
                            if (w_dec.is_mul && (MUL_CYCLES > 1)) begin
                                r_state     <= S_WAIT;
                                r_mul_cnt   <= MC_LOAD;
                                r_out_valid <= 1'b0;
                            end else begin
                                r_state     <= S_HOLD;
                                r_out_valid <= 1'b1;
                            end
                        end else if ((r_state == S_HOLD) && bus.out_ready) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                endcase
            end

            if (w_xfer && (r_op_count != {CNT_W{1'b1}}))
                r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.illegal   = r_illegal;
    assign bus.busy      = (r_state == S_WAIT);
    assign bus.op_count  = r_op_count;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencer instances (default, and MUL_CYCLES=1/CNT_W=2) driven
// with directed and random decode traffic, compared against a transaction-level model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       t_flush, t_valid, t_oready, t_f75, t_f70;
    logic [1:0] t_op;
    logic [2:0] t_f3;

    alu_op_sequencer_if #(.CTRL_W(4), .CNT_W(16)) ifa ();
    alu_op_sequencer_if #(.CTRL_W(4), .CNT_W(2))  ifb ();

    assign ifa.flush = t_flush;  assign ifb.flush = t_flush;
    assign ifa.in_valid = t_valid;  assign ifb.in_valid = t_valid;
    assign ifa.out_ready = t_oready;  assign ifb.out_ready = t_oready;
    assign ifa.alu_op = t_op;  assign ifb.alu_op = t_op;
    assign ifa.func3 = t_f3;  assign ifb.func3 = t_f3;
    assign ifa.func7_5 = t_f75;  assign ifb.func7_5 = t_f75;
    assign ifa.func7_0 = t_f70;  assign ifb.func7_0 = t_f70;

    alu_op_sequencer #(.CTRL_W(4), .MUL_CYCLES(3), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    alu_op_sequencer #(.CTRL_W(4), .MUL_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: per instance, a held result and the number of edges left before a MUL lands.
    int base_code [8] = '{0, 7, 5, 4, 6, 8, 3, 2};
    int lat  [2] = '{3, 1};
    int cmax [2] = '{65535, 3};
    bit m_has [2];
    int m_wait [2];
    int m_ctrl [2];
    bit m_ill [2];
    int m_cnt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_has[k] = 0; m_wait[k] = 0; m_ctrl[k] = 0; m_ill[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_decode(output int code, output bit ill, output bit mul);
        code = 0; ill = 0; mul = 0;
        case (t_op)
            2'd0: code = 0;
            2'd1: code = 1;
            2'd2: begin
                if (t_f70) begin
                    if (t_f3 == 3'd0) begin code = 10; mul = 1; end
                    else ill = 1;
                end else begin
                    code = base_code[t_f3] + (((t_f3 == 3'd0) || (t_f3 == 3'd5)) && t_f75 ? 1 : 0);
                end
            end
            default: code = base_code[t_f3] + ((t_f3 == 3'd5) && t_f75 ? 1 : 0);
        endcase
    endtask

    function automatic bit exp_ready(input int k);
        return !t_flush && (m_wait[k] == 0) && (!m_has[k] || t_oready);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit x;
            int code;
            bit ill, mul;
            x = t_valid && exp_ready(k);
            if (t_flush) begin
                m_has[k] = 0;
                m_wait[k] = 0;
            end else if (m_wait[k] > 0) begin
                m_wait[k]--;
                if (m_wait[k] == 0) m_has[k] = 1;
            end else if (x) begin
                model_decode(code, ill, mul);
                m_ctrl[k] = code;
                m_ill[k]  = ill;
                if (mul && lat[k] > 1) begin
                    m_has[k]  = 0;
                    m_wait[k] = lat[k] - 1;
                end else begin
                    m_has[k] = 1;
                end
            end else if (m_has[k] && t_oready) begin
                m_has[k] = 0;
            end
            if (x && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_inst(input string nm, input int k, input logic ov, input logic bz,
                              input logic [3:0] ctrl, input logic ill, input logic [31:0] cnt);
        check({nm, ".out_valid"}, 32'(ov), 32'(m_has[k]));
        check({nm, ".busy"}, 32'(bz), 32'(m_wait[k] > 0));
        check({nm, ".op_count"}, cnt, 32'(m_cnt[k]));
        if (m_has[k]) begin
            check({nm, ".alu_ctrl"}, 32'(ctrl), 32'(m_ctrl[k]));
            check({nm, ".illegal"}, 32'(ill), 32'(m_ill[k]));
        end
    endtask

    task automatic check_all();
        check_inst("A", 0, ifa.out_valid, ifa.busy, ifa.alu_ctrl, ifa.illegal, 32'(ifa.op_count));
        check_inst("B", 1, ifb.out_valid, ifb.busy, ifb.alu_ctrl, ifb.illegal, 32'(ifb.op_count));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".A.out_valid"}, 32'(ifa.out_valid), 0);
        check({tag, ".A.alu_ctrl"},  32'(ifa.alu_ctrl), 0);
        check({tag, ".A.illegal"},   32'(ifa.illegal), 0);
        check({tag, ".A.busy"},      32'(ifa.busy), 0);
        check({tag, ".A.op_count"},  32'(ifa.op_count), 0);
        check({tag, ".B.out_valid"}, 32'(ifb.out_valid), 0);
        check({tag, ".B.op_count"},  32'(ifb.op_count), 0);
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        #1;
        check("A.in_ready", 32'(ifa.in_ready), 32'(exp_ready(0)));
        check("B.in_ready", 32'(ifb.in_ready), 32'(exp_ready(1)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        t_flush = 0; t_valid = 0; t_oready = 1;
        t_op = 2'd0; t_f3 = 3'd0; t_f75 = 0; t_f70 = 0;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                          input logic f70);
        t_valid = 1; t_op = op; t_f3 = f3; t_f75 = f75; t_f70 = f70;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 0;
        #1;
        model_reset();
        check_zero(tag);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1;
        step();

        // SRA from R-type
        set_op(2'd2, 3'd5, 1, 0);
        step();
        check("sra.out_valid", 32'(ifa.out_valid), 1);
        check("sra.alu_ctrl", 32'(ifa.alu_ctrl), 9);
        check("sra.illegal", 32'(ifa.illegal), 0);
        idle_inputs();
        step();

        // MUL: three-cycle on A, single-cycle on B
        set_op(2'd2, 3'd0, 0, 1);
        step();
        check("mul.A.busy1", 32'(ifa.busy), 1);
        check("mul.B.out_valid", 32'(ifb.out_valid), 1);
        check("mul.B.alu_ctrl", 32'(ifb.alu_ctrl), 10);
        idle_inputs();
        #1 check("mul.A.in_ready", 32'(ifa.in_ready), 0);
        step();
        check("mul.A.busy2", 32'(ifa.busy), 1);
        check("mul.A.out_valid_early", 32'(ifa.out_valid), 0);
        step();
        check("mul.A.out_valid", 32'(ifa.out_valid), 1);
        check("mul.A.alu_ctrl", 32'(ifa.alu_ctrl), 10);
        check("mul.A.busy_done", 32'(ifa.busy), 0);
        step();

        // Unsupported M-extension funct3
        set_op(2'd2, 3'd4, 0, 1);
        step();
        check("ill.illegal", 32'(ifa.illegal), 1);
        check("ill.alu_ctrl", 32'(ifa.alu_ctrl), 0);
        check("ill.op_count", 32'(ifa.op_count), 3);
        idle_inputs();
        step();

        // ADD then OR, with a stalled consumer in between, then back-to-back
        set_op(2'd0, 3'd0, 0, 0);
        step();
        check("b2b.add", 32'(ifa.alu_ctrl), 0);
        set_op(2'd2, 3'd6, 0, 0);
        t_oready = 0;
        #1 check("stall.in_ready", 32'(ifa.in_ready), 0);
        step();
        check("stall.alu_ctrl", 32'(ifa.alu_ctrl), 0);
        check("stall.out_valid", 32'(ifa.out_valid), 1);
        t_oready = 1;
        step();
        check("b2b.or_after_stall", 32'(ifa.alu_ctrl), 3);
        set_op(2'd0, 3'd0, 0, 0);
        step();
        check("b2b.add2", 32'(ifa.alu_ctrl), 0);
        set_op(2'd2, 3'd6, 0, 0);
        step();
        check("b2b.or", 32'(ifa.alu_ctrl), 3);
        check("b2b.out_valid", 32'(ifa.out_valid), 1);
        idle_inputs();
        step();

        // Flush during WAIT
        set_op(2'd2, 3'd0, 0, 1);
        step();
        idle_inputs();
        t_flush = 1;
        step();
        check("flush.busy", 32'(ifa.busy), 0);
        check("flush.out_valid", 32'(ifa.out_valid), 0);
        t_flush = 0;
        step();

        // Async reset while holding a result
        set_op(2'd3, 3'd7, 0, 0);
        step();
        idle_inputs();
        t_oready = 0;
        step();
        pulse_reset("rst_hold");
        step();

        // Async reset mid-WAIT, then a fresh ADD must land with latency 1
        set_op(2'd2, 3'd0, 0, 1);
        step();
        idle_inputs();
        pulse_reset("rst_wait");
        for (int i = 0; i < 5; i++) begin
            set_op(2'd0, 3'd0, 0, 0);
            step();
            if (i == 0) check("after_rst.out_valid", 32'(ifa.out_valid), 1);
        end
        check("sat.A.op_count", 32'(ifa.op_count), 5);
        check("sat.B.op_count", 32'(ifb.op_count), 3);
        idle_inputs();
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            t_flush  = ($urandom_range(0, 15) == 0);
            t_valid  = ($urandom_range(0, 3) != 0);
            t_oready = ($urandom_range(0, 3) != 0);
            t_op     = 2'($urandom_range(0, 3));
            t_f3     = 3'($urandom_range(0, 7));
            t_f75    = 1'($urandom_range(0, 1));
            t_f70    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                t_op = 2'd2; t_f3 = 3'd0; t_f70 = 1;
            end
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
